// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage types and constants: FSM states, reset PC, widths, PC step.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_GAP,
    ST_HOLD,
    ST_DISCARD
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h8000_0000;
  localparam int          ADDRES_BIT_DEFAULT = 32;
  localparam int          INS_BIT_DEFAULT    = 32;
  localparam int          PC_INC             = 4;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Memory request/complete port plus decode valid/ready port, seen from the fetch unit (master).
interface instruction_fetch_unit_if
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDRES_BIT = ADDRES_BIT_DEFAULT,
  parameter int INS_BIT    = INS_BIT_DEFAULT
);
  logic [ADDRES_BIT-1:0] mem_ins_address_o;
  logic                  mem_get_instruction_o;
  logic [INS_BIT-1:0]    mem_read_ins_i;
  logic                  mem_instruction_completed_i;
  logic                  ins_valid_o;
  logic                  ins_ready_i;
  logic [INS_BIT-1:0]    ins_o;
  logic [ADDRES_BIT-1:0] ins_pc_o;

  modport master (
    output mem_ins_address_o, mem_get_instruction_o, ins_valid_o, ins_o, ins_pc_o,
    input  mem_read_ins_i, mem_instruction_completed_i, ins_ready_i
  );

  modport slave (
    input  mem_ins_address_o, mem_get_instruction_o, ins_valid_o, ins_o, ins_pc_o,
    output mem_read_ins_i, mem_instruction_completed_i, ins_ready_i
  );
endinterface

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// fetch_buffer: shift FIFO of DEPTH (1 or 2) entries, head is entry 0; no bypass, push visible next cycle.
// Push while full is accepted only with a same-edge pop; flush empties it and beats push/pop.
module fetch_buffer #(
  parameter int DEPTH = 1,
  parameter int W     = 64
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [W-1:0] head_dat_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int CW = (DEPTH > 1) ? 2 : 1;

  logic [CW-1:0]             cnt_q, cnt_d, cnt_pop;
  logic [DEPTH-1:0][W-1:0]   ent_q, ent_d;
  logic                      do_pop, do_push;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    cnt_pop = cnt_q - CW'(do_pop);
    cnt_d   = flush_i ? '0 : cnt_pop + CW'(do_push);
  end

  // A push lands in the first slot left free after the shift caused by a pop.
  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic [W-1:0] shift_src;
    if (k + 1 < DEPTH) begin : g_shift
      assign shift_src = ent_q[k+1];
    end else begin : g_tail
      assign shift_src = ent_q[k];
    end
    assign ent_d[k] = flush_i                          ? ent_q[k]   :
                      (do_push && cnt_pop == CW'(k))   ? push_dat_i :
                      do_pop                           ? shift_src  : ent_q[k];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ent_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ent_q <= ent_d;
    end
  end

  assign head_dat_o = ent_q[0];
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, runs the memory request/complete handshake, queues {word, pc} for decode.
// FETCH_SKID_BUFFER_EN selects a 2-entry output queue; otherwise a single output register.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                    ADDRES_BIT = ADDRES_BIT_DEFAULT,
  parameter int                    INS_BIT    = INS_BIT_DEFAULT,
  parameter logic [ADDRES_BIT-1:0] RESET_PC   = ADDRES_BIT'(RESET_PC_DEFAULT)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  instruction_fetch_unit_if.master fetch_if,
  input  logic                    redirect_i,
  input  logic [ADDRES_BIT-1:0]   redirect_pc_i
);
`ifdef FETCH_SKID_BUFFER_EN
  localparam int BUF_DEPTH = 2;
`else
  localparam int BUF_DEPTH = 1;
`endif

  fetch_state_e          state_q, state_d;
  logic [ADDRES_BIT-1:0] pc_q, pc_d;
  logic [ADDRES_BIT-1:0] pend_pc_q, pend_pc_d;
  logic [ADDRES_BIT-1:0] redir_pc;
  logic                  cmp, pop, slot_free;
  logic                  buf_push, buf_flush, buf_full, buf_empty;
  logic [INS_BIT+ADDRES_BIT-1:0] head_dat;

  assign redir_pc  = redirect_pc_i & ~ADDRES_BIT'(3);
  assign cmp       = fetch_if.mem_instruction_completed_i;
  assign pop       = ~buf_empty & fetch_if.ins_ready_i;
  assign slot_free = ~buf_full | pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_GAP;
      pc_q      <= RESET_PC;
      pend_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    buf_push  = 1'b0;
    buf_flush = 1'b0;
    case (state_q)
      ST_REQ: begin
        if (redirect_i) begin
          buf_flush = 1'b1;
          if (cmp) begin
            pc_d    = redir_pc;
            state_d = ST_GAP;
          end else begin
            // Memory must still finish the open request before we can move on.
            pend_pc_d = redir_pc;
            state_d   = ST_DISCARD;
          end
        end else if (cmp) begin
          buf_push = 1'b1;
          pc_d     = pc_q + ADDRES_BIT'(PC_INC);
          state_d  = ST_GAP;
        end
      end
      ST_GAP, ST_HOLD: begin
        if (redirect_i) begin
          buf_flush = 1'b1;
          pc_d      = redir_pc;
          state_d   = ST_GAP;
        end else begin
          state_d = slot_free ? ST_REQ : ST_HOLD;
        end
      end
      ST_DISCARD: begin
        if (redirect_i) begin
          buf_flush = 1'b1;
          if (cmp) begin
            pc_d    = redir_pc;
            state_d = ST_GAP;
          end else begin
            pend_pc_d = redir_pc;
          end
        end else if (cmp) begin
          pc_d    = pend_pc_q;
          state_d = ST_GAP;
        end
      end
      default: state_d = ST_GAP;
    endcase
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .W     (INS_BIT + ADDRES_BIT)
  ) u_fetch_buffer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (buf_push),
    .push_dat_i ({fetch_if.mem_read_ins_i, pc_q}),
    .pop_i      (pop),
    .flush_i    (buf_flush),
    .head_dat_o (head_dat),
    .full_o     (buf_full),
    .empty_o    (buf_empty)
  );

  assign fetch_if.mem_get_instruction_o = (state_q == ST_REQ) || (state_q == ST_DISCARD);
  assign fetch_if.mem_ins_address_o     = pc_q;
  assign fetch_if.ins_valid_o           = ~buf_empty;
  assign {fetch_if.ins_o, fetch_if.ins_pc_o} = head_dat;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a variable-latency memory model and decode-side monitor.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam logic [31:0] K     = 32'h5A5A_C3C3;
  localparam logic [31:0] RSTPC = 32'h8000_0000;
`ifdef FETCH_SKID_BUFFER_EN
  localparam int BURST_GAP = 1;
`else
  localparam int BURST_GAP = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ready = 1'b1;
  int unsigned mem_lat = 0;
  int unsigned mem_cnt = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .fetch_if      (bus),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc)
  );

  // Memory: completion combinational once the request has been high mem_lat cycles.
  always @(posedge clk) mem_cnt <= bus.mem_get_instruction_o ? mem_cnt + 1 : 0;
  assign bus.mem_instruction_completed_i = bus.mem_get_instruction_o && (mem_cnt >= mem_lat);
  assign bus.mem_read_ins_i = bus.mem_instruction_completed_i ? (bus.mem_ins_address_o ^ K) : 32'h0;
  assign bus.ins_ready_i    = ready;

  logic [31:0] acc_pc[$];
  logic [31:0] acc_ins[$];
  int          acc_cyc[$];
  int          runs[$];
  int          cyc = 0;
  int          run_len = 0;
  logic [31:0] run_addr = '0;
  int          unstable = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_ni && bus.ins_valid_o && bus.ins_ready_i) begin
      acc_pc.push_back(bus.ins_pc_o);
      acc_ins.push_back(bus.ins_o);
      acc_cyc.push_back(cyc);
    end
    if (rst_ni && bus.mem_get_instruction_o) begin
      if (run_len != 0 && bus.mem_ins_address_o != run_addr) unstable <= unstable + 1;
      run_len  <= run_len + 1;
      run_addr <= bus.mem_ins_address_o;
    end else if (run_len != 0) begin
      runs.push_back(run_len);
      run_len <= 0;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    acc_pc.delete();
    acc_ins.delete();
    acc_cyc.delete();
    runs.delete();
  endtask

  task automatic wait_acc(input string tag, input int n, input int budget);
    for (int b = 0; b < budget && acc_pc.size() < n; b++) step(1);
    chk(tag, 32'(acc_pc.size()), 32'(n));
  endtask

  task automatic wait_req_start(input string tag, input int budget);
    for (int b = 0; b < budget && !(bus.mem_get_instruction_o && mem_cnt == 0); b++) step(1);
    chk(tag, 32'(bus.mem_get_instruction_o && mem_cnt == 0), 32'd1);
  endtask

  task automatic wait_cmp(input string tag, input int budget);
    for (int b = 0; b < budget && !bus.mem_instruction_completed_i; b++) step(1);
    chk(tag, 32'(bus.mem_instruction_completed_i), 32'd1);
  endtask

  task automatic chk_seq(input string tag, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      if (acc_pc.size() > i) begin
        chk($sformatf("%s_pc%0d", tag, i), acc_pc[i], base + 32'(4 * i));
        chk($sformatf("%s_ins%0d", tag, i), acc_ins[i], (base + 32'(4 * i)) ^ K);
      end
    end
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    step(1);
    redirect    = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(bus.mem_get_instruction_o), 32'd0);
    chk({tag, "_addr"}, bus.mem_ins_address_o, RSTPC);
    chk({tag, "_vld"}, 32'(bus.ins_valid_o), 32'd0);
    chk({tag, "_ins"}, bus.ins_o, 32'd0);
    chk({tag, "_pc"}, bus.ins_pc_o, 32'd0);
  endtask

  logic [31:0] infl;

  initial begin
    step(3);
    chk_reset_vals("rst");

    // Zero-latency memory, decode always ready.
    rst_ni = 1'b1;
    step(1);
    chk("first_req", 32'(bus.mem_get_instruction_o), 32'd1);
    chk("first_addr", bus.mem_ins_address_o, RSTPC);
    step(1);
    chk("cmp_vld", 32'(bus.ins_valid_o), 32'd1);
    chk("cmp_pc", bus.ins_pc_o, RSTPC);
    wait_acc("p1_cnt", 3, 20);
    chk_seq("p1", RSTPC, 3);
    if (acc_cyc.size() >= 3) begin
      chk("p1_rate01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
      chk("p1_rate12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);
    end

    // Latency 3: each request held 4 cycles at a stable address.
    mem_lat = 3;
    do_redirect(32'h8000_0040);
    clear_mon();
    wait_acc("p2_cnt", 3, 80);
    chk_seq("p2", 32'h8000_0040, 3);
    if (runs.size() >= 3) begin
      chk("p2_run0", 32'(runs[runs.size()-3]), 32'd4);
      chk("p2_run1", 32'(runs[runs.size()-2]), 32'd4);
      chk("p2_run2", 32'(runs[runs.size()-1]), 32'd4);
    end
    chk("p2_stable", 32'(unstable), 32'd0);

    // Decode stall: buffer fills, request parks low, then drains in order.
    mem_lat = 0;
    ready   = 1'b0;
    do_redirect(32'h8000_0080);
    clear_mon();
    step(10);
    chk("hold_req", 32'(bus.mem_get_instruction_o), 32'd0);
    chk("hold_vld", 32'(bus.ins_valid_o), 32'd1);
    chk("hold_head", bus.ins_pc_o, 32'h8000_0080);
    ready = 1'b1;
    wait_acc("p3_cnt", 4, 30);
    chk_seq("p3", 32'h8000_0080, 4);
    if (acc_cyc.size() >= 2)
      chk("p3_burst", 32'(acc_cyc[1] - acc_cyc[0]), 32'(BURST_GAP));

    // Redirect into an open request: in-flight word is dropped, low PC bits cleared.
    mem_lat = 3;
    wait_req_start("p4_start", 40);
    infl = bus.mem_ins_address_o;
    do_redirect(32'h8000_0103);
    chk("p4_flush", 32'(bus.ins_valid_o), 32'd0);
    chk("p4_req_held", 32'(bus.mem_get_instruction_o), 32'd1);
    chk("p4_addr_held", bus.mem_ins_address_o, infl);
    clear_mon();
    wait_acc("p4_cnt", 2, 60);
    chk_seq("p4", 32'h8000_0100, 2);

    // Redirect on the completion edge, then redirect into DISCARD, then override the pending PC.
    wait_cmp("p5_cmp", 40);
    do_redirect(32'h8000_0300);
    clear_mon();
    chk("p5_drop_vld", 32'(bus.ins_valid_o), 32'd0);
    chk("p5_gap", 32'(bus.mem_get_instruction_o), 32'd0);
    step(1);
    chk("p5_reqA", bus.mem_ins_address_o, 32'h8000_0300);
    do_redirect(32'h8000_0400);
    chk("p5_disc_req", 32'(bus.mem_get_instruction_o), 32'd1);
    step(1);
    do_redirect(32'h8000_0500);
    chk("p5_disc_addr", bus.mem_ins_address_o, 32'h8000_0300);
    wait_acc("p5_cnt", 1, 40);
    chk_seq("p5", 32'h8000_0500, 1);

    // Asynchronous reset in the middle of a request.
    wait_req_start("p6_start", 40);
    step(1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_reset_vals("arst");
    step(2);
    rst_ni = 1'b1;
    clear_mon();
    step(1);
    chk("p6_req", 32'(bus.mem_get_instruction_o), 32'd1);
    chk("p6_addr", bus.mem_ins_address_o, RSTPC);
    wait_acc("p6_cnt", 2, 40);
    chk_seq("p6", RSTPC, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
